// File: rtl/bgd_sdiv_pkg.sv
// Shared types and constants for the sequential signed divider.
// Optional remainder output is enabled by defining BGD_SDIV_REM_EN.
package bgd_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int SDIV_WIDTH = 14;
    localparam int SDIV_CNT_W = $clog2(SDIV_WIDTH);

endpackage

// File: rtl/bgd_sdiv_step.sv
// One radix-2 restoring division step on unsigned magnitudes (WIDTH+1 bits).
module bgd_sdiv_step #(
    parameter int WIDTH = 14
) (
    input  logic [WIDTH:0] rem_in,
    input  logic           bit_in,
    input  logic [WIDTH:0] divisor,
    output logic [WIDTH:0] rem_out,
    output logic           q_bit
);

    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;

    assign trial = {rem_in, bit_in};
    assign diff  = trial - {1'b0, divisor};

    // A clear top bit means the trial subtraction did not borrow.
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : trial[WIDTH:0];

endmodule

// File: rtl/bgd_sdiv_seq_14s.sv
// Sequential signed divider: WIDTH restoring steps, then a sign-fix cycle.
// Define BGD_SDIV_REM_EN to add the signed remainder output.
module bgd_sdiv_seq_14s
    import bgd_sdiv_pkg::*;
#(
    parameter int WIDTH = SDIV_WIDTH,
    parameter int ID    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             start,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
`ifdef BGD_SDIV_REM_EN
    output logic [WIDTH-1:0] rem,
`endif
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH);

    if (ID < 0 || WIDTH < 2) begin : g_param_check
        $error("bgd_sdiv_seq_14s: invalid ID or WIDTH");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH:0]   dvsr;
    logic             sign_a, sign_b, zero_div;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH:0]   din1_ext;
    logic [WIDTH:0]   din1_abs;
    logic [WIDTH-1:0] din0_abs;

    // The dividend magnitude (at most 2^(WIDTH-1)) fits WIDTH unsigned bits,
    // so it shifts through quo; the divisor keeps the extra bit.
    assign din0_abs = din0[WIDTH-1] ? -din0 : din0;
    assign din1_ext = {din1[WIDTH-1], din1};
    assign din1_abs = din1[WIDTH-1] ? -din1_ext : din1_ext;

    bgd_sdiv_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (part_rem),
        .bit_in  (quo[WIDTH-1]),
        .divisor (dvsr),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: datapath and outputs are reset too, so an aborted division leaves no stale result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            quo      <= '0;
            part_rem <= '0;
            dvsr     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            zero_div <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            dz       <= 1'b0;
`ifdef BGD_SDIV_REM_EN
            rem      <= '0;
`endif
        end else if (ce) begin
            done <= (state == FIX);
            busy <= (state != IDLE) || start;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        quo      <= din0_abs;
                        dvsr     <= din1_abs;
                        part_rem <= '0;
                        sign_a   <= din0[WIDTH-1];
                        sign_b   <= din1[WIDTH-1];
                        zero_div <= (din1 == '0);
                        cnt      <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    quo      <= {quo[WIDTH-2:0], step_bit};
                    part_rem <= step_rem;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    dz   <= zero_div;
                    dout <= zero_div ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
`ifdef BGD_SDIV_REM_EN
                    // With a zero divisor the magnitude equals |din0|, so this restores din0.
                    rem  <= sign_a ? -part_rem[WIDTH-1:0] : part_rem[WIDTH-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bgd_sdiv_seq_14s.sv
// Directed self-checking bench for bgd_sdiv_seq_14s (WIDTH=14).
module tb_bgd_sdiv_seq_14s;

    localparam int W = 14;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce;
    logic         start;
    logic [W-1:0] din0;
    logic [W-1:0] din1;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         dz;
`ifdef BGD_SDIV_REM_EN
    logic [W-1:0] rem;
`endif

    int total = 0;
    int bad   = 0;

    bgd_sdiv_seq_14s #(.WIDTH(W), .ID(1)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
`ifdef BGD_SDIV_REM_EN
        .rem   (rem),
`endif
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one division and wait for done; lat counts cycles after the accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] q,
                          output logic [W-1:0] r, output logic z);
        din0  = a;
        din1  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        q = dout;
        z = dz;
`ifdef BGD_SDIV_REM_EN
        r = rem;
`else
        r = '0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b1;
        din0  = 14'd100;
        din1  = 14'd7;
        repeat (3) tick();
        total++;
        if ({busy, done, dz} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: busy/done/dz=%b expected 000", {busy, done, dz});
        end
        total++;
        if (dout !== '0) begin
            bad++;
            $display("FAIL reset_dout: got %0h expected 0", dout);
        end
`ifdef BGD_SDIV_REM_EN
        total++;
        if (rem !== '0) begin
            bad++;
            $display("FAIL reset_rem: got %0h expected 0", rem);
        end
`endif
        start = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_arith();
        vec_t vecs [10];
        int   lat;
        logic [W-1:0] q, r;
        logic z;
        vecs = '{
            '{14'd100,    14'd7,      14'd14,     14'd2,    1'b0},
            '{-14'sd100,  14'd7,      -14'sd14,   -14'sd2,  1'b0},
            '{14'd100,    -14'sd7,    -14'sd14,   14'd2,    1'b0},
            '{-14'sd100,  -14'sd7,    14'd14,     -14'sd2,  1'b0},
            '{14'h2000,   14'h3FFF,   14'h2000,   14'd0,    1'b0},
            '{14'h2000,   14'd1,      14'h2000,   14'd0,    1'b0},
            '{14'd5,      14'd0,      14'h3FFF,   14'd5,    1'b1},
            '{14'd9,      14'd3,      14'd3,      14'd0,    1'b0},
            '{14'd8191,   14'h2000,   14'd0,      14'd8191, 1'b0},
            '{14'h2000,   14'h2000,   14'd1,      14'd0,    1'b0}
        };
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, q, r, z);
            total++;
            if (lat !== 16) begin
                bad++;
                $display("FAIL arith_latency[%0d]: got %0d cycles expected 16", i, lat);
            end
            total++;
            if (q !== vecs[i].q) begin
                bad++;
                $display("FAIL arith_dout[%0d]: got %0h expected %0h", i, q, vecs[i].q);
            end
            total++;
            if (z !== vecs[i].z) begin
                bad++;
                $display("FAIL arith_dz[%0d]: got %b expected %b", i, z, vecs[i].z);
            end
`ifdef BGD_SDIV_REM_EN
            total++;
            if (r !== vecs[i].r) begin
                bad++;
                $display("FAIL arith_rem[%0d]: got %0h expected %0h", i, r, vecs[i].r);
            end
`endif
        end
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL arith_idle: busy/done=%b expected 00", {busy, done});
        end
    endtask

    // Previous result is 1 (from -8192 / -8192); a second start mid-CALC must be dropped.
    task automatic test_ce_and_ignore();
        int n;
        din0  = 14'd100;
        din1  = 14'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        total++;
        if (busy !== 1'b1 || dout !== 14'd1) begin
            bad++;
            $display("FAIL ce_hold_prev: busy=%b dout=%0h expected busy=1 dout=1", busy, dout);
        end
        while (done !== 1'b1 && n < 60) begin
            if (n == 2) begin
                start = 1'b1;
                din0  = 14'd50;
                din1  = 14'd5;
            end
            if (n == 3) start = 1'b0;
            if (n == 5) ce = 1'b0;
            if (n == 10) ce = 1'b1;
            if (n == 8) begin
                total++;
                if ({busy, done} !== 2'b10) begin
                    bad++;
                    $display("FAIL ce_frozen: busy/done=%b expected 10", {busy, done});
                end
            end
            tick();
            n++;
        end
        total++;
        if (n !== 21 || done !== 1'b1) begin
            bad++;
            $display("FAIL ce_latency: done=%b at cycle %0d expected cycle 21", done, n);
        end
        total++;
        if (dout !== 14'd14) begin
            bad++;
            $display("FAIL ce_dout: got %0d expected 14", dout);
        end
`ifdef BGD_SDIV_REM_EN
        total++;
        if (rem !== 14'd2) begin
            bad++;
            $display("FAIL ce_rem: got %0d expected 2", rem);
        end
`endif
        ce = 1'b0;
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL ce_done_hold: got %b expected 1", done);
        end
        ce = 1'b1;
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL ce_done_pulse: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] q, r;
        logic z;
        run_op(14'd9, 14'd3, lat, q, r, z);
        din0  = 14'd50;
        din1  = 14'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_accept: busy/done=%b expected 10", {busy, done});
        end
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 16 || dout !== 14'd10) begin
            bad++;
            $display("FAIL b2b_result: lat=%0d dout=%0d expected lat=16 dout=10", lat, dout);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [W-1:0] q, r;
        logic z;
        din0  = 14'd77;
        din1  = 14'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, done, dz} !== 3'b000 || dout !== '0) begin
            bad++;
            $display("FAIL abort_immediate: busy/done/dz=%b dout=%0h expected 000/0",
                     {busy, done, dz}, dout);
        end
        tick();
        tick();
        reset = 1'b0;
        run_op(14'd50, 14'd5, lat, q, r, z);
        total++;
        if (lat !== 16) begin
            bad++;
            $display("FAIL abort_restart_latency: got %0d expected 16", lat);
        end
        total++;
        if (q !== 14'd10 || z !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart_dout: dout=%0d dz=%b expected 10/0", q, z);
        end
`ifdef BGD_SDIV_REM_EN
        total++;
        if (r !== 14'd0) begin
            bad++;
            $display("FAIL abort_restart_rem: got %0d expected 0", r);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ce_and_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
